// File: rtl/ram_block_mover_pkg.sv
// ram_block_mover_pkg: shared types and default sizing for the RAM block mover.
//   state_e   : mover FSM states
//   WIDTH_DEF : default data word width
//   DEPTH_DEF : default address width (RAM holds 2**DEPTH words)
package ram_block_mover_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_e;
endpackage

// File: rtl/ram_block_mover_if.sv
// ram_block_mover_if: request/status handshake plus the single-port RAM bus.
//   Start/SrcAddr/DstAddr/Len : transfer request (from requester)
//   Busy/Done                 : transfer status (from mover)
//   MemAddr/MemDatain/MemWe   : RAM command (from mover)
//   MemDataout                : registered RAM read data (from RAM)
//   Checksum                  : sum of written words, only with RAM_BLOCK_MOVER_CSUM_EN
// slave = the mover, master = requester/RAM side.
interface ram_block_mover_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic             Start;
  logic [DEPTH-1:0] SrcAddr;
  logic [DEPTH-1:0] DstAddr;
  logic [DEPTH:0]   Len;
  logic             Busy;
  logic             Done;
  logic [DEPTH-1:0] MemAddr;
  logic [WIDTH-1:0] MemDatain;
  logic             MemWe;
  logic [WIDTH-1:0] MemDataout;
`ifdef RAM_BLOCK_MOVER_CSUM_EN
  logic [WIDTH-1:0] Checksum;

  modport slave  (input  Start, SrcAddr, DstAddr, Len, MemDataout,
                  output Busy, Done, MemAddr, MemDatain, MemWe, Checksum);
  modport master (output Start, SrcAddr, DstAddr, Len, MemDataout,
                  input  Busy, Done, MemAddr, MemDatain, MemWe, Checksum);
`else
  modport slave  (input  Start, SrcAddr, DstAddr, Len, MemDataout,
                  output Busy, Done, MemAddr, MemDatain, MemWe);
  modport master (output Start, SrcAddr, DstAddr, Len, MemDataout,
                  input  Busy, Done, MemAddr, MemDatain, MemWe);
`endif
endinterface

// File: rtl/ram_block_mover.sv
// ram_block_mover: copies Len words from SrcAddr to DstAddr in an external
// synchronous single-port RAM, ascending, one word per RD/CAP/WR triple.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ram_block_mover_if.slave (request, status, RAM bus)
// Optional macro RAM_BLOCK_MOVER_CSUM_EN adds bus.Checksum, the modular sum
// of the words written by the most recent transfer.
module ram_block_mover
  import ram_block_mover_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_block_mover_if.slave  bus
);
  state_e           state_q, state_d;
  logic [DEPTH-1:0] src_q, src_d;
  logic [DEPTH-1:0] dst_q, dst_d;
  logic [DEPTH:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [DEPTH:0]   cnt_dec;

  assign cnt_dec = cnt_q - (DEPTH+1)'(1);

  // state register + datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.Start) state_d = (bus.Len == '0) ? FIN : RD;
      RD:   state_d = CAP;
      CAP:  state_d = WR;
      WR:   state_d = (cnt_dec != '0) ? RD : FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath next values; request fields are latched only on acceptance
  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (bus.Start && bus.Len != '0) begin
        src_d = bus.SrcAddr;
        dst_d = bus.DstAddr;
        cnt_d = bus.Len;
      end
      CAP:  data_d = bus.MemDataout;
      WR: begin
        src_d = src_q + DEPTH'(1);   // natural wrap modulo 2**DEPTH
        dst_d = dst_q + DEPTH'(1);
        cnt_d = cnt_dec;
      end
      default: ;
    endcase
  end

  // outputs (decoded from state, so reset clears them asynchronously)
  always_comb begin
    bus.Busy      = 1'b0;
    bus.Done      = 1'b0;
    bus.MemWe     = 1'b0;
    bus.MemAddr   = '0;
    bus.MemDatain = '0;
    case (state_q)
      RD, CAP: begin
        bus.Busy    = 1'b1;
        bus.MemAddr = src_q;
      end
      WR: begin
        bus.Busy      = 1'b1;
        bus.MemWe     = 1'b1;
        bus.MemAddr   = dst_q;
        bus.MemDatain = data_q;
      end
      FIN: bus.Done = 1'b1;
      default: ;
    endcase
  end

`ifdef RAM_BLOCK_MOVER_CSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  // cleared on any acceptance (Len=0 included), accumulated on each write
  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && bus.Start) csum_d = '0;
    else if (state_q == WR)           csum_d = csum_q + data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign bus.Checksum = csum_q;
`endif
endmodule

// File: tb/tb_ram_block_mover.sv
// tb_ram_block_mover: directed + randomized transfers against a word-by-word
// array copy model; checks memory image, Done timing, Busy/MemWe counts,
// reset/abort behaviour and (with RAM_BLOCK_MOVER_CSUM_EN) Checksum.
module tb_ram_block_mover;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int N     = 1 << DEPTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_block_mover_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  ram_block_mover #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [WIDTH-1:0] mem     [N];
  logic [WIDTH-1:0] img     [N];
  logic [WIDTH-1:0] ref_mem [N];
  logic             load = 1'b0;

  // synchronous single-port RAM with a whole-image backdoor load
  always @(posedge clk) begin
    if (load)           mem <= img;
    else if (bus.MemWe) mem[bus.MemAddr] <= bus.MemDatain;
    else                bus.MemDataout   <= mem[bus.MemAddr];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_img();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int i = 0; i < N; i++) ref_mem[i] = img[i];
  endtask

  task automatic rand_img();
    for (int i = 0; i < N; i++) img[i] = $urandom;
    load_img();
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = N - 1; i >= 0; i--) if (mem[i] !== ref_mem[i]) bad = i;
    check(tag, mem[bad], ref_mem[bad]);
  endtask

  // Reference: ascending word copy, each read seeing earlier writes.
  function automatic logic [WIDTH-1:0] model_copy(input int s, input int d, input int l);
    logic [WIDTH-1:0] cs;
    cs = '0;
    for (int i = 0; i < l; i++) begin
      ref_mem[(d + i) % N] = ref_mem[(s + i) % N];
      cs += ref_mem[(d + i) % N];
    end
    return cs;
  endfunction

  // One transfer; mid=1 fires a stray Start with junk fields while busy (l>=2).
  task automatic run_xfer(input string tag, input int s, input int d, input int l, input bit mid);
    int done_at, busy_n, we_n, done_n;
    logic [WIDTH-1:0] cs;
    done_at = -1; busy_n = 0; we_n = 0; done_n = 0;
    @(posedge clk); #1;
    bus.Start   = 1'b1;
    bus.SrcAddr = DEPTH'(s);
    bus.DstAddr = DEPTH'(d);
    bus.Len     = (DEPTH+1)'(l);
    for (int k = 1; k <= 3 * l + 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        bus.Start   = 1'b0;
        bus.SrcAddr = DEPTH'($urandom);
        bus.DstAddr = DEPTH'($urandom);
        bus.Len     = (DEPTH+1)'($urandom);
      end
      if (mid && k == 4) begin
        bus.Start   = 1'b1;
        bus.SrcAddr = DEPTH'($urandom);
        bus.DstAddr = DEPTH'($urandom);
        bus.Len     = (DEPTH+1)'($urandom_range(1, 9));
      end
      if (mid && k == 5) bus.Start = 1'b0;
      if (bus.Busy)  busy_n++;
      if (bus.MemWe) we_n++;
      if (bus.Done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
    end
    cs = model_copy(s, d, l);
    check({tag, ".done_edge"}, done_at, 3 * l + 1);
    check({tag, ".done_cnt"},  done_n, 1);
    check({tag, ".busy_cyc"},  busy_n, 3 * l);
    check({tag, ".we_cyc"},    we_n, l);
    check({tag, ".idle_out"},  {bus.Busy, bus.MemWe, bus.MemAddr, bus.MemDatain}, '0);
    cmp_mem({tag, ".mem"});
`ifdef RAM_BLOCK_MOVER_CSUM_EN
    check({tag, ".csum"}, bus.Checksum, cs);
`else
    if (cs === 'x) $display("checksum model undefined");
`endif
  endtask

  initial begin
    int s, d, l;
    bus.Start = 1'b0; bus.SrcAddr = '0; bus.DstAddr = '0; bus.Len = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset.out", {bus.Busy, bus.Done, bus.MemWe, bus.MemAddr, bus.MemDatain}, '0);
`ifdef RAM_BLOCK_MOVER_CSUM_EN
    check("reset.csum", bus.Checksum, 0);
`endif
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // basic copy
    for (int i = 0; i < N; i++) img[i] = $urandom;
    img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
    load_img();
    run_xfer("copy", 0, 16, 4, 1'b0);
    check("copy.w16", mem[16], 32'h11);
    check("copy.w19", mem[19], 32'h44);

    // wrap at top of memory
    rand_img();
    run_xfer("wrap", 254, 10, 4, 1'b0);
    check("wrap.w12", mem[12], img[0]);
    check("wrap.w13", mem[13], img[1]);

    // zero-length
    run_xfer("len0", 5, 9, 0, 1'b0);

    // overlapping ascending copy propagates
    img[0] = 32'hA; img[1] = 32'hB; img[2] = 32'hC;
    load_img();
    run_xfer("ovl", 0, 1, 2, 1'b0);
    check("ovl.w1", mem[1], 32'hA);
    check("ovl.w2", mem[2], 32'hA);

`ifdef RAM_BLOCK_MOVER_CSUM_EN
    img[0] = 32'hFFFF_FFFF; img[1] = 32'h0000_0002;
    load_img();
    run_xfer("csum", 0, 64, 2, 1'b1);
    check("csum.val", bus.Checksum, 32'h1);
`endif

    // randomized transfers, each with a stray Start while busy
    for (int t = 0; t < 8; t++) begin
      if (t % 3 == 0) rand_img();
      s = $urandom_range(0, N - 1);
      d = $urandom_range(0, N - 1);
      l = $urandom_range(2, 24);
      run_xfer("rand", s, d, l, 1'b1);
    end

    // full-memory copy
    rand_img();
    run_xfer("full", 7, 107, N, 1'b0);

    // abort during second WR of a Len=4 copy
    rand_img();
    @(posedge clk); #1;
    bus.Start = 1'b1; bus.SrcAddr = 8'd32; bus.DstAddr = 8'd64; bus.Len = 9'd4;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.Start = 1'b0;
    end
    check("abort.in_wr", bus.MemWe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort.out", {bus.Busy, bus.Done, bus.MemWe, bus.MemAddr, bus.MemDatain}, '0);
`ifdef RAM_BLOCK_MOVER_CSUM_EN
    check("abort.csum", bus.Checksum, 0);
`endif
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    begin
      int dn;
      dn = 0;
      for (int k = 0; k < 15; k++) begin
        @(posedge clk); #1;
        if (bus.Done || bus.Busy) dn++;
      end
      check("abort.no_done", dn, 0);
    end
    // reset landed before the second write edge: exactly one word moved
    void'(model_copy(32, 64, 1));
    cmp_mem("abort.mem");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
